uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receive engine: the next generation of our fixed 8N1 serial receiver. It adds configurable data width, parity and stop bits, 3-sample majority voting, and frame/parity error reporting. It also adds a valid/ready output holding register with overrun detection. It sits between the host serial pin and the sequence-loader command parser, in the same clock domain as the parser.

## Interface
- CLK_PER_BIT, 200: system clocks per serial bit; legal range 8..4095.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

- c_rx  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rxd  in  1  raw serial line, asynchronous; idle high.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- rx_data  out  8  received word, LSB = first data bit; bits above DATA_BITS-1 are 0.
- rx_valid  out  1  rx_data/rx_frame_err/rx_par_err hold a word; stays high until accepted.
- rx_frame_err  out  1  captured with word: a stop bit sampled 0.
- rx_par_err  out  1  captured with word: parity mismatch; always 0 when PARITY = 0.
- rx_overrun  out  1  one-cycle pulse: a completed word was dropped.
- rx_busy  out  1  high in every state except IDLE.

## Operation
- rxd passes a 2-FF synchroniser (rx_s). A 3-bit history register holds the last three rx_s values. The sample value is the majority of the three.
- Bit counter width is clog2(CLK_PER_BIT). It resets to 0 on every state change.
- IDLE: when rx_s = 0, go to START.
- START: count to (CLK_PER_BIT-1)/2, then evaluate the majority.
  - Majority 0: go to DATA.
  - Majority 1: go to IDLE (glitch reject; no flags).
- DATA: at each count = CLK_PER_BIT-1, shift in the majority value LSB-first.
  - After DATA_BITS samples, go to PARITY if PARITY != 0, otherwise to STOP.
- PARITY: sample once at CLK_PER_BIT-1.
  - par_err = XOR(data, parity bit) XOR (PARITY == 1). Odd parity therefore expects an odd count of ones including the parity bit.
- STOP: sample STOP_BITS times at CLK_PER_BIT-1. frame_err is set if any stop sample is 0.
  - After the last sample, go to DONE. No wait for the end of the stop bit, so back-to-back frames are caught.
- DONE: one cycle; go to IDLE.
  - Output register free (rx_valid = 0, or rx_ready = 1 this cycle): load data, frame_err and par_err, and set rx_valid.
  - Otherwise: keep the old word and pulse rx_overrun.
- Consumer handshake: rx_valid & rx_ready clears rx_valid, except when DONE loads a new word in the same cycle, in which case rx_valid stays 1.
- A framing error does not suppress the word; the word is delivered with rx_frame_err = 1. This includes a break (all-zero data with frame error).

## Timing
- Reset (async assert, sync release): state = IDLE, counter = 0, history = 3'b111, synchroniser = 1.
  - All outputs 0: rx_data = 0, rx_valid = 0, both error flags 0, rx_overrun = 0, rx_busy = 0.
- Reset mid-frame aborts the frame; no word and no overrun result.
- Latency: rx_valid rises 1 cycle after the final stop-bit sample.
  - That is about (1 + DATA_BITS + P + STOP_BITS - 0.5) x CLK_PER_BIT + 3 cycles after the rxd falling edge, where P = 1 if parity is enabled, else 0.
- rx_data and the error flags are stable while rx_valid = 1 and change only on a DONE load.
- rx_overrun is high for exactly one cycle, coincident with DONE.
- A new start bit is accepted from the cycle after DONE.
- rx_busy goes high the cycle after rx_s is first seen low.

## Test plan
Unless noted, CLK_PER_BIT = 16 and rx_ready is held at 1.
- 8N1: send 0xA5 -> one word with rx_data = 0xA5, both error flags 0; rx_valid high 1 cycle; rx_busy back to 0.
- 7E1 (DATA_BITS = 7, PARITY = 2):
  - Send 0x41 with correct parity bit 0 -> rx_data = 0x41, rx_par_err = 0.
  - Repeat with the parity bit flipped -> rx_par_err = 1, data still 0x41.
- Framing/break: send 0x00 with the stop bit held low -> rx_data = 0x00, rx_frame_err = 1.
  - Then release the line and send 0x3C -> clean word.
- Glitch: pulse rxd low for 3 clocks -> no rx_valid, rx_busy returns to 0 within CLK_PER_BIT/2 + 3 cycles.
  - A 1-clock low spike inside a data bit, timed at the sample point, does not corrupt the word (majority vote).
- Overrun/handshake: rx_ready = 0; send 0x11 then 0x22 back-to-back -> rx_data stays 0x11 and rx_overrun pulses once.
  - Assert rx_ready in the same cycle as the third word's DONE -> 0x11 accepted, 0x33 loaded, rx_valid stays 1, no overrun.
- Reset: assert rst_n low mid-data-bit 4 -> all outputs 0 immediately.
  - After release, the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// UART receive engine with configurable data width, parity and stop bits.
// Uses 3-sample majority voting and a valid/ready holding register with overrun pulse.
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       c_rx,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_par_err,
  output logic       rx_overrun,
  output logic       rx_busy,
  output logic [2:0] rx_state
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF      = CW'((CLK_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST      = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state;
  logic          rx_m, rx_s;
  logic [2:0]    hist;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shreg;
  logic          frame_err;
  logic          par_err;
  logic          maj;
  logic          bit_done;

  assign maj      = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign bit_done = (cnt == LAST);
  assign rx_busy  = (state != S_IDLE);
  assign rx_state = state;

  // Output handshake: a word is transferred on any cycle where rx_valid and
  // rx_ready are both high; rx_valid then drops unless DONE reloads it in
  // that same cycle. While rx_valid is high the word and its flags are frozen.
  always_ff @(posedge c_rx or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      hist         <= 3'b111;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      frame_err    <= 1'b0;
      par_err      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_par_err   <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_m       <= rxd;
      rx_s       <= rx_m;
      hist       <= {hist[1:0], rx_s};
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!maj) begin
              state     <= S_DATA;
              bit_idx   <= '0;
              shreg     <= '0;
              frame_err <= 1'b0;
              par_err   <= 1'b0;
            end else begin
              state <= S_IDLE;  // glitch: line was not really low mid start bit
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt            <= '0;
            shreg[bit_idx] <= maj;
            if (bit_idx == LAST_DATA) begin
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            cnt     <= '0;
            par_err <= (^shreg) ^ maj ^ ODD;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (!maj) frame_err <= 1'b1;
            // Leave straight after the mid-bit sample so a back-to-back start bit is caught.
            if (stop_idx == LAST_STOP) state <= S_DONE;
            else stop_idx <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
          if (!rx_valid || rx_ready) begin
            rx_data      <= shreg;
            rx_frame_err <= frame_err;
            rx_par_err   <= par_err;
            rx_valid     <= 1'b1;
          end else begin
            rx_overrun <= 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance (a) and a 7E1 instance (b), both at 16 clocks/bit,
// driven by a serial-line task and checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ovr_a, ovr_b, busy_a, busy_b;
  logic [2:0] state_a, state_b;

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .c_rx(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_ready(ready_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_frame_err(fe_a), .rx_par_err(pe_a),
    .rx_overrun(ovr_a), .rx_busy(busy_a), .rx_state(state_a)
  );

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .c_rx(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_ready(ready_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_frame_err(fe_b), .rx_par_err(pe_b),
    .rx_overrun(ovr_b), .rx_busy(busy_b), .rx_state(state_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [9:0] exp_q_a[$], exp_q_b[$];
  logic [9:0] got_q_a[$], got_q_b[$];
  int ovr_cnt_a = 0, ovr_cnt_b = 0, vcyc_a = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a) vcyc_a++;
      if (valid_a && ready_a) got_q_a.push_back({fe_a, pe_a, data_a});
      if (valid_b && ready_b) got_q_b.push_back({fe_b, pe_b, data_b});
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  // Sends one frame. Instance a is 8N1, instance b is 7E1. The expected word comes
  // from counting ones on what was actually put on the wire.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit par_flip,
                            input bit stop_low, input int spike_bit, input int abort_bit,
                            input bit record);
    int nb, pm, nbits, ones;
    logic [7:0] dm;
    logic [10:0] bits;
    logic pbit, v, exp_pe;
    nb = (sel == 0) ? 8 : 7;
    pm = (sel == 0) ? 0 : 2;
    dm = d & 8'((1 << nb) - 1);
    pbit = ($countones(dm) % 2 == 1);
    if (pm == 1) pbit = ~pbit;
    pbit = pbit ^ par_flip;
    bits = '0;
    nbits = 0;
    bits[nbits] = 1'b0; nbits++;
    for (int i = 0; i < nb; i++) begin bits[nbits] = dm[i]; nbits++; end
    if (pm != 0) begin bits[nbits] = pbit; nbits++; end
    bits[nbits] = ~stop_low; nbits++;
    ones = $countones(dm) + ((pm != 0) ? int'(pbit) : 0);
    exp_pe = (pm == 1) ? (ones % 2 == 0) : (pm == 2) ? (ones % 2 == 1) : 1'b0;
    if (record) begin
      if (sel == 0) exp_q_a.push_back({stop_low, exp_pe, dm});
      else exp_q_b.push_back({stop_low, exp_pe, dm});
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        v = bits[b];
        if (b == spike_bit && c == CPB / 2) v = 1'b0;
        if (b == abort_bit && c == CPB / 2) begin
          rst_n = 1'b0;
          return;
        end
        set_line(sel, v);
        tick();
      end
    end
    set_line(sel, 1'b1);
  endtask

  task automatic expect_words(input int sel);
    int n;
    logic [9:0] g, e;
    n = (sel == 0) ? exp_q_a.size() : exp_q_b.size();
    for (int i = 0; i < 4 * CPB; i++) begin
      if (((sel == 0) ? got_q_a.size() : got_q_b.size()) >= n) break;
      tick();
    end
    if (sel == 0) begin
      check("word_count_a", got_q_a.size(), n);
      while (got_q_a.size() > 0 && exp_q_a.size() > 0) begin
        g = got_q_a.pop_front(); e = exp_q_a.pop_front();
        check("word_a", 32'(g), 32'(e));
      end
      got_q_a.delete(); exp_q_a.delete();
    end else begin
      check("word_count_b", got_q_b.size(), n);
      while (got_q_b.size() > 0 && exp_q_b.size() > 0) begin
        g = got_q_b.pop_front(); e = exp_q_b.pop_front();
        check("word_b", 32'(g), 32'(e));
      end
      got_q_b.delete(); exp_q_b.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int seen, len, found, sel, sl;
    logic [7:0] d;
    bit flip;

    repeat (3) tick();
    check("rst_valid_a", 32'(valid_a), 0);
    check("rst_busy_a", 32'(busy_a), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_data_a", 32'(data_a), 0);
    check("idle_flags_a", 32'({fe_a, pe_a, ovr_a, valid_a, busy_a}), 0);
    check("idle_flags_b", 32'({data_b, fe_b, pe_b, ovr_b, valid_b, busy_b}), 0);

    // 8N1 single word
    send_frame(0, 8'hA5, 0, 0, -1, -1, 1);
    expect_words(0);
    check("a5_valid_cycles", vcyc_a, 1);
    repeat (2) tick();
    check("a5_busy_idle", 32'(busy_a), 0);

    // 7E1 good and bad parity
    send_frame(1, 8'h41, 0, 0, -1, -1, 1);
    expect_words(1);
    repeat (CPB) tick();
    send_frame(1, 8'h41, 1, 0, -1, -1, 1);
    expect_words(1);
    repeat (CPB) tick();

    // Break with stop bit low, then a clean word
    send_frame(0, 8'h00, 0, 1, -1, -1, 1);
    expect_words(0);
    repeat (2 * CPB) tick();
    send_frame(0, 8'h3C, 0, 0, -1, -1, 1);
    expect_words(0);
    repeat (CPB) tick();

    // 3-clock glitch on the idle line
    seen = 0; len = 0;
    rxd_b = 1'b0;
    repeat (3) tick();
    rxd_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy_b) begin seen = 1; len++; end
      else if (seen != 0) break;
      tick();
    end
    check("glitch_busy_seen", seen, 1);
    check("glitch_busy_short", 32'(len <= CPB / 2 + 3), 1);
    repeat (CPB) tick();
    expect_words(1);

    // 1-clock low spike at the sample point of data bit 6 (a '1')
    send_frame(0, 8'hF0, 0, 0, 7, -1, 1);
    expect_words(0);
    repeat (CPB) tick();

    // Overrun, then accept in the same cycle as the third word's DONE
    ready_a = 1'b0;
    send_frame(0, 8'h11, 0, 0, -1, -1, 1);
    check("ovr_none_yet", ovr_cnt_a, 0);
    send_frame(0, 8'h22, 0, 0, -1, -1, 0);
    check("ovr_once", ovr_cnt_a, 1);
    check("ovr_hold_data", 32'(data_a), 32'h11);
    check("ovr_hold_valid", 32'(valid_a), 1);
    found = 0;
    fork
      send_frame(0, 8'h33, 0, 0, -1, -1, 1);
      begin
        for (int i = 0; i < 12 * CPB; i++) begin
          tick();
          if (state_a == 3'd5) begin ready_a = 1'b1; found = 1; break; end
        end
        if (found != 0) begin
          tick();
          check("same_cycle_valid", 32'(valid_a), 1);
          check("same_cycle_data", 32'(data_a), 32'h33);
          check("same_cycle_ovr", 32'(ovr_a), 0);
        end
      end
    join
    check("done_seen", found, 1);
    ready_a = 1'b1;
    expect_words(0);
    check("ovr_still_once", ovr_cnt_a, 1);
    repeat (CPB) tick();

    // Reset in the middle of data bit 4 with a word pending
    ready_a = 1'b0;
    send_frame(0, 8'h77, 0, 0, -1, -1, 0);
    repeat (2) tick();
    check("pre_rst_valid", 32'(valid_a), 1);
    send_frame(0, 8'hC3, 0, 0, 5, 5, 0);
    #1;
    check("mid_rst_data", 32'(data_a), 0);
    check("mid_rst_flags", 32'({valid_a, fe_a, pe_a, ovr_a, busy_a}), 0);
    repeat (3) tick();
    rxd_a = 1'b1;
    ready_a = 1'b1;
    rst_n = 1'b1;
    repeat (2 * CPB) tick();
    check("post_rst_no_word", got_q_a.size(), 0);
    check("post_rst_no_ovr", ovr_cnt_a, 1);
    send_frame(0, 8'h5A, 0, 0, -1, -1, 1);
    expect_words(0);
    repeat (CPB) tick();

    // Randomized frames on both instances
    for (int it = 0; it < 20; it++) begin
      sel = $urandom_range(0, 1);
      d = 8'($urandom_range(0, 255));
      flip = (sel == 1) && ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 5) == 0) ? 1 : 0;
      send_frame(sel, d, flip, sl != 0, -1, -1, 1);
      expect_words(sel);
      repeat (CPB + $urandom_range(0, CPB) + 2 * CPB * sl) tick();
    end

    check("final_ovr_a", ovr_cnt_a, 1);
    check("final_ovr_b", ovr_cnt_b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
